// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch stage (FETCH_MISALIGN_TRAP_EN adds HALT)
package fetch_pkg;
`ifdef FETCH_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
`else
    typedef enum logic [1:0] {BOOT, RUN} state_t;
`endif
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] PC_INC = 32'd4;
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [31:0] instruction;
    } if_id_t;
    localparam if_id_t BUBBLE = '{valid: 1'b0, pc: 32'd0, pc_plus4: 32'd0, instruction: NOP};
endpackage

// File: rtl/if_id_register.sv
// if_id_register: IF/ID pipeline register with bubble, load and hold controls
module if_id_register
    import fetch_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   i_load,
    input  logic   i_bubble,
    input  logic   i_hold,
    input  if_id_t i_d,
    output if_id_t o_q
);
    if_id_t r_q;
    // bubble wins over load; hold freezes the current contents
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_q <= BUBBLE;
        else if (i_bubble)
            r_q <= BUBBLE;
        else if (i_load && !i_hold)
            r_q <= i_d;
    end
    assign o_q = r_q;
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC, boot FSM and fetch counter feeding IF/ID (FETCH_MISALIGN_TRAP_EN enables misaligned-redirect trap)
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                  PC_WIDTH          = 32,
    parameter int                  ADDRESS_WIDTH     = 9,
    parameter int                  INSTRUCTION_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC          = 32'h0000_0000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         Stall,
    input  logic                         Flush,
    input  logic                         RedirectValid,
    input  logic [PC_WIDTH-1:0]          RedirectTarget,
    output logic [ADDRESS_WIDTH-1:0]     Address,
    input  logic [INSTRUCTION_WIDTH-1:0] Instruction,
    output logic                         IfIdValid,
    output logic [PC_WIDTH-1:0]          IfIdPc,
    output logic [PC_WIDTH-1:0]          IfIdPcPlus4,
    output logic [INSTRUCTION_WIDTH-1:0] IfIdInstruction,
    output logic [31:0]                  FetchCount,
    output logic                         MisalignTrap
);
    state_t                r_state;
    state_t                w_state_next;
    logic [PC_WIDTH-1:0]   r_pc;
    logic [PC_WIDTH-1:0]   w_pc_next;
    logic [PC_WIDTH-1:0]   w_pc_plus4;
    logic [31:0]           r_fetch_count;
    logic                  w_load;
    logic                  w_bubble;
    logic                  w_hold;
    logic                  w_trap_set;
    if_id_t                w_capture;
    if_id_t                w_if_id;

    assign w_pc_plus4 = r_pc + PC_WIDTH'(PC_INC);
    assign Address    = r_pc[ADDRESS_WIDTH-1:0];

    // state, PC and fetch counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= BOOT;
            r_pc          <= RESET_PC;
            r_fetch_count <= '0;
        end else begin
            r_state       <= w_state_next;
            r_pc          <= w_pc_next;
            r_fetch_count <= r_fetch_count + {31'd0, w_load};
        end
    end

    // next state, next PC and IF/ID controls; redirect beats flush beats stall
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_load       = 1'b0;
        w_bubble     = 1'b0;
        w_hold       = 1'b1;
        w_trap_set   = 1'b0;
        case (r_state)
            BOOT: w_state_next = RUN;
            RUN: begin
                if (RedirectValid) begin
                    w_pc_next = RedirectTarget;
                    w_bubble  = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
                    if (RedirectTarget[1:0] != 2'b00) begin
                        w_trap_set   = 1'b1;
                        w_state_next = HALT;
                    end
`endif
                end else if (Flush) begin
                    w_bubble  = 1'b1;
                    w_pc_next = Stall ? r_pc : w_pc_plus4;
                end else if (!Stall) begin
                    w_pc_next = w_pc_plus4;
                    w_load    = 1'b1;
                    w_hold    = 1'b0;
                end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            HALT: w_bubble = 1'b1;
`endif
            default: w_state_next = BOOT;
        endcase
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    logic r_trap;
    // sticky trap flag, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_trap <= 1'b0;
        else if (w_trap_set)
            r_trap <= 1'b1;
    end
    assign MisalignTrap = r_trap;
`else
    assign MisalignTrap = 1'b0;
    logic w_unused_trap;
    assign w_unused_trap = w_trap_set;
`endif

    assign w_capture = '{valid: 1'b1, pc: r_pc, pc_plus4: w_pc_plus4, instruction: Instruction};

    if_id_register u_if_id (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_load),
        .i_bubble (w_bubble),
        .i_hold   (w_hold),
        .i_d      (w_capture),
        .o_q      (w_if_id)
    );

    assign IfIdValid       = w_if_id.valid;
    assign IfIdPc          = w_if_id.pc;
    assign IfIdPcPlus4     = w_if_id.pc_plus4;
    assign IfIdInstruction = w_if_id.instruction;
    assign FetchCount      = r_fetch_count;
endmodule
